product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Downstream consumer of the 4-bit combinational multiplier's 8-bit product.
- Accepts products over a valid/ready handshake and sums a fixed-size batch of COUNT products.
- Presents the batch sum on a valid/ready output port; this is the accumulate half of a multiply-accumulate datapath.

Parameters:
- PROD_W, 8, input product width; matches the multiplier result width.
- ACC_W, 10, accumulator and output width.
- COUNT, 8, products per batch; must be >= 2.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- io_clear  input  1  synchronous abort of the current batch.
- io_in_valid  input  1  product beat valid.
- io_in_ready  output  1  block can accept a product.
- io_in_bits  input  PROD_W  unsigned product.
- io_out_valid  output  1  batch sum available.
- io_out_ready  input  1  consumer accepts sum.
- io_out_bits  output  ACC_W  batch sum.
- io_out_sat  output  1  batch saturated; tied 0 unless the optional feature is enabled.

Behaviour:
- State machine has two states:
  - ACCUM: collecting products.
  - FULL: sum held for the consumer.
- Registers: acc (ACC_W), cnt (width clog2(COUNT)), sat flag (1 bit).
- Reset (async, immediate): state=ACCUM, acc=0, cnt=0, sat=0. Output values while in reset: io_out_valid=0, io_out_bits=0, io_out_sat=0, io_in_ready=1.
- ACCUM:
  - io_in_ready=1, io_out_valid=0.
  - An in-fire is io_in_valid & io_in_ready.
  - On in-fire: acc <= acc + zero-extended io_in_bits, cnt <= cnt+1.
  - On in-fire with cnt==COUNT-1: state <= FULL and cnt <= 0. The final sum is visible on io_out_bits with io_out_valid=1 the cycle after the last beat (latency 1).
- FULL:
  - io_out_valid=1 and io_out_bits=acc; both held stable until io_out_ready.
  - io_in_ready = io_out_ready (pass-through, no combinational path from io_in_valid).
  - out-fire with no in-fire: state <= ACCUM, acc <= 0, sat <= 0.
  - out-fire and in-fire in the same cycle: state <= ACCUM, acc <= io_in_bits, cnt <= 1, sat <= 0.
  - This gives full throughput: one batch per COUNT cycles.
- Arithmetic:
  - Unsigned only.
  - Without saturation, the sum wraps modulo 2^ACC_W.
  - Add is computed ACC_W+1 wide; the carry bit is used only by the optional feature.
- io_clear:
  - Highest priority below reset, in any state.
  - Next state: ACCUM, acc=0, cnt=0, sat=0.
  - Any in-beat or out-beat in the same cycle is discarded: the handshake may complete at the ports, but the data is dropped.
  - io_out_valid falls the next cycle.
- Outputs are registered or derived from state only. No combinational path from io_in_bits to io_out_*.

Optional Feature:
- Macro PRODUCT_ACC_SAT_EN.
- Defined:
  - If the ACC_W+1-bit sum exceeds 2^ACC_W-1, acc <= 2^ACC_W-1 and sat <= 1.
  - Once saturated, acc stays at max for the rest of the batch.
  - io_out_sat = sat while in FULL, else 0.
- Undefined:
  - Wrap-around arithmetic.
  - sat register absent; io_out_sat tied 0.
- The port list is identical in both builds.

Decomposition:
- Shared package holds:
  - state enum {ACCUM, FULL};
  - default constants PROD_W=8, ACC_W=10, COUNT=8;
  - a localparam function for counter width (clog2).
- One natural sub-module: acc_add_sat. It is combinational: acc + product, with the saturation path selected by PRODUCT_ACC_SAT_EN, producing next_acc and sat_hit.
- FSM, counter and handshake logic stay in the top.

Test Plan:
- Reset mid-batch: feed 3 products of 10, assert reset asynchronously -> acc=0, io_out_valid=0, io_in_ready=1 immediately. A fresh batch of 8x1 then gives io_out_bits=8.
- Basic batch: 8 beats of values 1..8 back-to-back, io_out_ready=1 -> io_out_valid rises the cycle after the 8th beat with io_out_bits=36.
- Backpressure: complete a batch with io_out_ready=0 for 5 cycles -> io_out_bits holds stable, io_in_ready=0; then io_out_ready=1 -> one out-fire, then return to ACCUM.
- Full throughput: 16 continuous beats of 225 with io_out_ready=1. The 9th beat is accepted in the FULL out-fire cycle.
  - Without PRODUCT_ACC_SAT_EN: two sums of 1800 mod 1024 = 776.
  - With PRODUCT_ACC_SAT_EN: two sums of 1023 with io_out_sat=1.
- io_clear: 4 beats of 50, then io_clear together with a beat of 50 -> that beat is discarded. Next 8 beats of 2 -> io_out_bits=16.
- Clear in FULL: batch done, io_out_valid=1, assert io_clear with io_out_ready=0 -> io_out_valid=0 next cycle and the sum is lost; a following batch of 8x3 gives 24.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// product_accumulator_pkg
//   Shared definitions for the product accumulator: FSM state type,
//   default parameter values and the counter-width helper.
//   Optional feature macro used by the design: PRODUCT_ACC_SAT_EN.
package product_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam int unsigned PROD_W_DEF = 8;
    localparam int unsigned ACC_W_DEF  = 10;
    localparam int unsigned COUNT_DEF  = 8;

    // Beat counter width; at least one bit even for tiny batches.
    function automatic int unsigned cnt_width(input int unsigned count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/product_accumulator_acc_add_sat.sv
// product_accumulator_acc_add_sat
//   Combinational accumulate step: i_acc + zero-extended i_prod, computed
//   ACC_W+1 bits wide. With PRODUCT_ACC_SAT_EN defined the carry clamps the
//   result to all-ones and raises o_sat_hit; otherwise the sum wraps and
//   o_sat_hit is 0.
//
//   Ports:
//     i_acc       [ACC_W-1:0]   current accumulator value
//     i_prod      [PROD_W-1:0]  unsigned product to add
//     o_next_acc  [ACC_W-1:0]   updated accumulator value
//     o_sat_hit                 sum overflowed ACC_W bits (saturating build only)
module product_accumulator_acc_add_sat
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_next_acc,
    output logic              o_sat_hit
);

    logic [ACC_W:0] w_sum;

    assign w_sum = {1'b0, i_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_prod};

`ifdef PRODUCT_ACC_SAT_EN
    assign o_sat_hit  = w_sum[ACC_W];
    assign o_next_acc = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    // Carry is dropped: the accumulator wraps modulo 2^ACC_W.
    logic w_unused_carry;
    assign w_unused_carry = w_sum[ACC_W];
    assign o_sat_hit      = 1'b0;
    assign o_next_acc     = w_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums batches of COUNT unsigned products received over a valid/ready
//   input and presents each batch sum on a valid/ready output. The input
//   handshake is accepted in the same cycle the held sum is consumed, so a
//   new batch starts without a bubble (one batch per COUNT cycles).
//   Optional saturation is enabled with the macro PRODUCT_ACC_SAT_EN.
//
//   Ports:
//     clock         rising-edge clock
//     reset         asynchronous active-high reset
//     io_clear      synchronous abort of the current batch (drops any beat)
//     io_in_valid   product beat valid
//     io_in_ready   block can accept a product
//     io_in_bits    unsigned product [PROD_W-1:0]
//     io_out_valid  batch sum available
//     io_out_ready  consumer accepts the sum
//     io_out_bits   batch sum [ACC_W-1:0]
//     io_out_sat    batch saturated (always 0 unless saturation is built in)
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned COUNT  = COUNT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_clear,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [PROD_W-1:0] io_in_bits,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [ACC_W-1:0]  io_out_bits,
    output logic              io_out_sat
);

    localparam int unsigned CntW = cnt_width(COUNT);
    localparam logic [CntW-1:0] LastCnt = CntW'(COUNT - 1);

    state_e          r_state;
    state_e          w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_next;
    logic [CntW-1:0]  r_cnt;
    logic [CntW-1:0]  w_cnt_next;

    logic             w_in_fire;
    logic             w_out_fire;
    logic [ACC_W-1:0] w_add_base;
    logic [ACC_W-1:0] w_add_result;
    logic             w_sat_hit;

    // Ready only depends on state and io_out_ready, never on io_in_valid.
    assign io_in_ready  = (r_state == ACCUM) | io_out_ready;
    assign io_out_valid = (r_state == FULL);
    assign io_out_bits  = (r_state == FULL) ? r_acc : '0;

    assign w_in_fire  = io_in_valid & io_in_ready;
    assign w_out_fire = (r_state == FULL) & io_out_ready;

    // In FULL an accepted beat opens a new batch, so the add starts from zero.
    assign w_add_base = (r_state == FULL) ? '0 : r_acc;

    product_accumulator_acc_add_sat #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_acc_add_sat (
        .i_acc      (w_add_base),
        .i_prod     (io_in_bits),
        .o_next_acc (w_add_result),
        .o_sat_hit  (w_sat_hit)
    );

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        if (io_clear) begin
            w_state_next = ACCUM;
            w_acc_next   = '0;
            w_cnt_next   = '0;
        end else begin
            unique case (r_state)
                ACCUM: begin
                    if (w_in_fire) begin
                        w_acc_next = w_add_result;
                        if (r_cnt == LastCnt) begin
                            w_state_next = FULL;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + CntW'(1);
                        end
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_state_next = ACCUM;
                        if (w_in_fire) begin
                            w_acc_next = w_add_result;
                            w_cnt_next = CntW'(1);
                        end else begin
                            w_acc_next = '0;
                            w_cnt_next = '0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
        end
    end

`ifdef PRODUCT_ACC_SAT_EN
    logic r_sat;
    logic w_sat_next;

    // Sticky for the batch; a batch opened in FULL starts from zero and
    // cannot overflow on its first beat, so it takes the fresh hit value.
    always_comb begin
        w_sat_next = r_sat;
        if (io_clear) begin
            w_sat_next = 1'b0;
        end else if ((r_state == ACCUM) && w_in_fire) begin
            w_sat_next = r_sat | w_sat_hit;
        end else if (w_out_fire) begin
            w_sat_next = w_in_fire & w_sat_hit;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sat <= 1'b0;
        end else begin
            r_sat <= w_sat_next;
        end
    end

    assign io_out_sat = (r_state == FULL) & r_sat;
`else
    logic w_unused_sat_hit;
    assign w_unused_sat_hit = w_sat_hit;
    assign io_out_sat       = 1'b0;
`endif

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
//   Scoreboard bench: a monitor sampling on the falling edge records every
//   accepted product, forms the batch sum with plain arithmetic when a batch
//   completes and queues it; each presented sum is compared with the queue
//   head. Directed scenarios are followed by a randomized phase.
module tb_product_accumulator;

    localparam int PROD_W  = 8;
    localparam int ACC_W   = 10;
    localparam int COUNT   = 8;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    typedef struct {
        int bits;
        int sat;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_clear;
    logic              io_in_valid;
    logic              io_in_ready;
    logic [PROD_W-1:0] io_in_bits;
    logic              io_out_valid;
    logic              io_out_ready;
    logic [ACC_W-1:0]  io_out_bits;
    logic              io_out_sat;

    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    int   last_out = -1;
    int   batch[$];
    exp_t exp_q[$];

    product_accumulator #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .COUNT  (COUNT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_clear     (io_clear),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_bits   (io_in_bits),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_bits  (io_out_bits),
        .io_out_sat   (io_out_sat)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t batch_sum(input int vals[$]);
        exp_t e;
        int   sum = 0;
        foreach (vals[i]) sum += vals[i];
`ifdef PRODUCT_ACC_SAT_EN
        e.sat  = (sum > ACC_MAX) ? 1 : 0;
        e.bits = (sum > ACC_MAX) ? ACC_MAX : sum;
`else
        e.sat  = 0;
        e.bits = sum % (ACC_MAX + 1);
`endif
        return e;
    endfunction

    // Monitor / scoreboard: check current outputs, then apply this cycle's
    // handshakes (which complete at the coming rising edge) to the model.
    always @(negedge clock) begin
        if (reset) begin
            batch.delete();
            exp_q.delete();
        end else begin
            chk("out_valid", io_out_valid, exp_q.size() != 0);
            chk("in_ready", io_in_ready, (exp_q.size() == 0) || io_out_ready);
            if (io_out_valid && exp_q.size() != 0) begin
                chk("out_bits", io_out_bits, exp_q[0].bits);
                chk("out_sat", io_out_sat, exp_q[0].sat);
                if (io_out_ready && !io_clear) begin
                    last_out = io_out_bits;
                    n_out++;
                end
                if (io_out_ready || io_clear) void'(exp_q.pop_front());
            end
            if (io_clear) begin
                batch.delete();
            end else if (io_in_valid && io_in_ready) begin
                batch.push_back(int'(io_in_bits));
                if (batch.size() == COUNT) begin
                    exp_q.push_back(batch_sum(batch));
                    batch.delete();
                end
            end
        end
    end

    task automatic step(input logic v, input logic [PROD_W-1:0] b, input logic rdy,
                        input logic clr);
        io_in_valid  = v;
        io_in_bits   = b;
        io_out_ready = rdy;
        io_clear     = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || io_out_valid) && k < 30) begin
            step(1'b0, '0, 1'b1, 1'b0);
            k++;
        end
        chk({name, "_drain"}, k < 30, 1);
    endtask

    initial begin
        int outs_before;
        int exp_tp;
        int exp_tp_sat;

`ifdef PRODUCT_ACC_SAT_EN
        exp_tp     = ACC_MAX;
        exp_tp_sat = 1;
`else
        exp_tp     = (8 * 225) % (ACC_MAX + 1);
        exp_tp_sat = 0;
`endif

        reset        = 1'b1;
        io_clear     = 1'b0;
        io_in_valid  = 1'b0;
        io_in_bits   = '0;
        io_out_ready = 1'b0;
        #1;
        chk("rst_out_valid", io_out_valid, 0);
        chk("rst_in_ready", io_in_ready, 1);
        chk("rst_out_bits", io_out_bits, 0);
        chk("rst_out_sat", io_out_sat, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Asynchronous reset in the middle of a batch.
        repeat (3) step(1'b1, 8'd10, 1'b1, 1'b0);
        io_in_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", io_out_valid, 0);
        chk("async_rst_in_ready", io_in_ready, 1);
        chk("async_rst_out_bits", io_out_bits, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (8) step(1'b1, 8'd1, 1'b1, 1'b0);
        drain("rst_batch");
        chk("rst_batch_sum", last_out, 8);

        // Basic batch 1..8, sum visible one cycle after the last beat.
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
        io_in_valid = 1'b0;
        chk("basic_valid_latency", io_out_valid, 1);
        chk("basic_bits_latency", io_out_bits, 36);
        drain("basic");
        chk("basic_sum", last_out, 36);

        // Backpressure: sum held stable and input stalled.
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'd99, 1'b0, 1'b0);
            chk("bp_in_ready", io_in_ready, 0);
            chk("bp_hold_bits", io_out_bits, 196);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        chk("bp_released", io_out_valid, 0);
        chk("bp_sum", last_out, 196);

        // Full throughput: beat 9 is accepted in the out-fire cycle.
        outs_before = n_out;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'd225, 1'b1, 1'b0);
            if (i == 7) chk("tp_sat_flag", io_out_sat, exp_tp_sat);
        end
        drain("tp");
        chk("tp_sum", last_out, exp_tp);
        chk("tp_batches", n_out - outs_before, 2);

        // Clear during accumulation discards the concurrent beat.
        repeat (4) step(1'b1, 8'd50, 1'b1, 1'b0);
        step(1'b1, 8'd50, 1'b1, 1'b1);
        repeat (8) step(1'b1, 8'd2, 1'b1, 1'b0);
        drain("clr");
        chk("clr_sum", last_out, 16);

        // Clear while holding a finished sum loses it.
        repeat (8) step(1'b1, 8'd7, 1'b0, 1'b0);
        chk("clrfull_valid", io_out_valid, 1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("clrfull_dropped", io_out_valid, 0);
        repeat (8) step(1'b1, 8'd3, 1'b1, 1'b0);
        drain("clrfull");
        chk("clrfull_sum", last_out, 24);

        // Randomized traffic with backpressure and occasional clears.
        outs_before = n_out;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end
        drain("rand");
        chk("rand_progress", n_out > outs_before, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
